// File: rtl/mem_stage_lsu_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave).
// The master raises dmem_req with stable we/addr/wdata/be and holds it until dmem_ack, which also qualifies dmem_rdata.
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage plus MEM/WB register: performs loads/stores over a req/ack port,
// aligns store lanes, extends load data, and stalls EX while an access is outstanding.
module mem_stage_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  // EX -> MEM: an instruction transfers when ex_valid && ex_ready && !flush.
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [1:0]      memtoreg_in,
  input  logic [XLEN-1:0] return_addr_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [XLEN-1:0] pc_off_in,
  input  logic [6:0]      opcode_in,
  input  logic [4:0]      rd_in,
  input  logic            regwrite_in,
  mem_stage_lsu_if.master dmem,
  output logic            wb_valid,
  output logic [XLEN-1:0] mem_out,
  output logic [XLEN-1:0] alu_out,
  output logic [1:0]      memtoreg,
  output logic [XLEN-1:0] return_addr,
  output logic [XLEN-1:0] imm_out,
  output logic [XLEN-1:0] pc_signed_offset,
  output logic [6:0]      opcode_out_d,
  output logic [4:0]      rd_out,
  output logic            regwrite_out,
  output logic            misalign,
  output logic            state_dbg
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t state, state_next;
  logic   accept;
  logic   finish;

  // Request decode
  logic [1:0]      lane;
  logic            is_mem, is_load, is_store;
  logic            size_byte, size_half;
  logic            misaligned;
  logic [3:0]      be_next;
  logic [XLEN-1:0] wdata_next;

  // Pending instruction held across the access
  logic [XLEN-1:0] pend_alu, pend_ret, pend_imm, pend_pcoff;
  logic [1:0]      pend_memtoreg;
  logic [6:0]      pend_opcode;
  logic [4:0]      pend_rd;
  logic            pend_regwrite;
  logic            pend_load;
  logic [2:0]      pend_funct3;
  logic [1:0]      pend_lane;

  logic            we_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [3:0]      be_q;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;

  assign lane     = alu_result[1:0];
  assign is_mem   = mem_read | mem_write;
  assign is_store = mem_write;
  assign is_load  = mem_read & ~mem_write;

  // Stores only know SB/SH/SW; every other store funct3 behaves as a word.
  assign size_byte = is_store ? (funct3 == 3'b000) : (funct3[1:0] == 2'b00);
  assign size_half = is_store ? (funct3 == 3'b001) : (funct3[1:0] == 2'b01);
  assign misaligned = is_mem & ((size_half & lane[0]) |
                                (~size_byte & ~size_half & (lane != 2'b00)));

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = store_data;
    if (is_store && size_byte) begin
      be_next    = 4'b0001 << lane;
      wdata_next = {4{store_data[7:0]}};
    end else if (is_store && size_half) begin
      be_next    = lane[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{store_data[15:0]}};
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid && !flush) begin
          accept = 1'b1;
          if (is_mem && !misaligned) state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (dmem.dmem_ack) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign ex_ready        = (state == IDLE);
  assign state_dbg       = (state == ACCESS);
  assign dmem.dmem_req   = (state == ACCESS);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

  always_comb begin
    ld_byte = dmem.dmem_rdata[7:0];
    case (pend_lane)
      2'd0: ld_byte = dmem.dmem_rdata[7:0];
      2'd1: ld_byte = dmem.dmem_rdata[15:8];
      2'd2: ld_byte = dmem.dmem_rdata[23:16];
      2'd3: ld_byte = dmem.dmem_rdata[31:24];
      default: ld_byte = dmem.dmem_rdata[7:0];
    endcase
    ld_half = pend_lane[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (pend_funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = dmem.dmem_rdata;
    endcase
  end

  // Capture a memory instruction and its bus request when it starts an access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_alu      <= '0;
      pend_ret      <= '0;
      pend_imm      <= '0;
      pend_pcoff    <= '0;
      pend_memtoreg <= '0;
      pend_opcode   <= '0;
      pend_rd       <= '0;
      pend_regwrite <= 1'b0;
      pend_load     <= 1'b0;
      pend_funct3   <= '0;
      pend_lane     <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
    end else if (accept && state_next == ACCESS) begin
      pend_alu      <= alu_result;
      pend_ret      <= return_addr_in;
      pend_imm      <= imm_in;
      pend_pcoff    <= pc_off_in;
      pend_memtoreg <= memtoreg_in;
      pend_opcode   <= opcode_in;
      pend_rd       <= rd_in;
      pend_regwrite <= regwrite_in;
      pend_load     <= is_load;
      pend_funct3   <= funct3;
      pend_lane     <= lane;
      we_q          <= is_store;
      addr_q        <= {alu_result[XLEN-1:2], 2'b00};
      wdata_q       <= wdata_next;
      be_q          <= be_next;
    end
  end

  // MEM/WB register: loaded either directly from EX (ALU op or misaligned access) or on ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid         <= 1'b0;
      mem_out          <= '0;
      alu_out          <= '0;
      memtoreg         <= '0;
      return_addr      <= '0;
      imm_out          <= '0;
      pc_signed_offset <= '0;
      opcode_out_d     <= '0;
      rd_out           <= '0;
      regwrite_out     <= 1'b0;
      misalign         <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      if (accept && state_next == IDLE) begin
        wb_valid         <= 1'b1;
        misalign         <= misaligned;
        mem_out          <= '0;
        alu_out          <= alu_result;
        memtoreg         <= memtoreg_in;
        return_addr      <= return_addr_in;
        imm_out          <= imm_in;
        pc_signed_offset <= pc_off_in;
        opcode_out_d     <= opcode_in;
        rd_out           <= rd_in;
        regwrite_out     <= regwrite_in & ~misaligned;
      end else if (finish) begin
        wb_valid         <= 1'b1;
        mem_out          <= pend_load ? ld_ext : '0;
        alu_out          <= pend_alu;
        memtoreg         <= pend_memtoreg;
        return_addr      <= pend_ret;
        imm_out          <= pend_imm;
        pc_signed_offset <= pend_pcoff;
        opcode_out_d     <= pend_opcode;
        rd_out           <= pend_rd;
        regwrite_out     <= pend_regwrite;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: loads, stores, misalignment, flush and reset during an access.
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, flush = 1'b0;
  logic        ex_ready;
  logic [31:0] alu_result = '0, store_data = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [1:0]  memtoreg_in = '0;
  logic [31:0] return_addr_in = '0, imm_in = '0, pc_off_in = '0;
  logic [6:0]  opcode_in = '0;
  logic [4:0]  rd_in = '0;
  logic        regwrite_in = 1'b0;
  logic        wb_valid, misalign, regwrite_out, state_dbg;
  logic [31:0] mem_out, alu_out, return_addr, imm_out, pc_signed_offset;
  logic [1:0]  memtoreg;
  logic [6:0]  opcode_out_d;
  logic [4:0]  rd_out;
  int          checks = 0;
  int          errors = 0;

  mem_stage_lsu_if dmem_bus ();

  mem_stage_lsu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .flush(flush),
    .alu_result(alu_result), .store_data(store_data),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .memtoreg_in(memtoreg_in), .return_addr_in(return_addr_in),
    .imm_in(imm_in), .pc_off_in(pc_off_in), .opcode_in(opcode_in),
    .rd_in(rd_in), .regwrite_in(regwrite_in),
    .dmem(dmem_bus),
    .wb_valid(wb_valid), .mem_out(mem_out), .alu_out(alu_out),
    .memtoreg(memtoreg), .return_addr(return_addr), .imm_out(imm_out),
    .pc_signed_offset(pc_signed_offset), .opcode_out_d(opcode_out_d),
    .rd_out(rd_out), .regwrite_out(regwrite_out), .misalign(misalign),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = '0;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; flush = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = '0; alu_result = '0; store_data = '0; rd_in = '0; regwrite_in = 1'b0;
    memtoreg_in = '0; return_addr_in = '0; imm_in = '0; pc_off_in = '0; opcode_in = '0;
  endtask

  task automatic drive_mem(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] rd_idx, input logic rw);
    ex_valid = 1'b1; flush = 1'b0; mem_read = rd; mem_write = wr; funct3 = f3;
    alu_result = addr; store_data = data; rd_in = rd_idx; regwrite_in = rw;
    memtoreg_in = 2'd1; opcode_in = wr ? 7'h23 : 7'h03;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready got %0h exp 1", ex_ready); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %0h exp 0", wb_valid); end
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0h exp 0", dmem_bus.dmem_req); end
    checks++; if (mem_out !== 32'h0 || alu_out !== 32'h0 || rd_out !== 5'h0) begin
      errors++; $display("FAIL reset_outputs got mem_out=%h alu_out=%h rd_out=%h exp all 0", mem_out, alu_out, rd_out);
    end
    checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL reset_state got %0h exp 0", state_dbg); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    drive_mem(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd5, 1'b1);
    tick();
    clear_ex();
    checks++; if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_we !== 1'b0) begin
      errors++; $display("FAIL lw_req got req=%0h we=%0h exp req=1 we=0", dmem_bus.dmem_req, dmem_bus.dmem_we);
    end
    checks++; if (dmem_bus.dmem_addr !== 32'h100 || dmem_bus.dmem_be !== 4'b1111) begin
      errors++; $display("FAIL lw_addr_be got addr=%h be=%b exp addr=00000100 be=1111", dmem_bus.dmem_addr, dmem_bus.dmem_be);
    end
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL lw_stall got %0h exp 0", ex_ready); end
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_bus.dmem_ack = 1'b0;
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL lw_req_drop got %0h exp 0", dmem_bus.dmem_req); end
    checks++; if (wb_valid !== 1'b1 || mem_out !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL lw_wb got wb_valid=%0h mem_out=%h exp 1 deadbeef", wb_valid, mem_out);
    end
    checks++; if (rd_out !== 5'd5 || regwrite_out !== 1'b1 || memtoreg !== 2'd1 || alu_out !== 32'h100) begin
      errors++; $display("FAIL lw_fields got rd=%0d rw=%0h m2r=%0d alu=%h exp 5 1 1 00000100", rd_out, regwrite_out, memtoreg, alu_out);
    end
    tick();
    checks++; if (wb_valid !== 1'b0 || mem_out !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL lw_pulse got wb_valid=%0h mem_out=%h exp 0 deadbeef", wb_valid, mem_out);
    end
  endtask

  task automatic test_lb_wait(input logic [2:0] f3, input logic [31:0] exp_data);
    int low_cycles;
    low_cycles = 0;
    drive_mem(1'b1, 1'b0, f3, 32'h0000_0103, 32'h0, 5'd9, 1'b1);
    tick();
    clear_ex();
    for (int i = 0; i < 3; i++) begin
      if (ex_ready === 1'b0) low_cycles++;
      checks++; if (dmem_bus.dmem_req !== 1'b1) begin errors++; $display("FAIL lb_wait_req got %0h exp 1", dmem_bus.dmem_req); end
      tick();
    end
    if (ex_ready === 1'b0) low_cycles++;
    checks++; if (dmem_bus.dmem_be !== 4'b1111 || dmem_bus.dmem_addr !== 32'h100) begin
      errors++; $display("FAIL lb_addr got addr=%h be=%b exp 00000100 1111", dmem_bus.dmem_addr, dmem_bus.dmem_be);
    end
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'h8000_0000;
    tick();
    dmem_bus.dmem_ack = 1'b0;
    checks++; if (low_cycles != 4 || ex_ready !== 1'b1) begin
      errors++; $display("FAIL lb_stall_len got %0d ready=%0h exp 4 1", low_cycles, ex_ready);
    end
    checks++; if (wb_valid !== 1'b1 || mem_out !== exp_data) begin
      errors++; $display("FAIL lb_data got wb_valid=%0h mem_out=%h exp 1 %h", wb_valid, mem_out, exp_data);
    end
    tick();
  endtask

  task automatic test_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    drive_mem(1'b0, 1'b1, f3, addr, data, 5'd0, 1'b0);
    tick();
    clear_ex();
    checks++; if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_we !== 1'b1) begin
      errors++; $display("FAIL st_req got req=%0h we=%0h exp 1 1", dmem_bus.dmem_req, dmem_bus.dmem_we);
    end
    checks++; if (dmem_bus.dmem_be !== exp_be || dmem_bus.dmem_wdata !== exp_wdata) begin
      errors++; $display("FAIL st_lanes got be=%b wdata=%h exp %b %h", dmem_bus.dmem_be, dmem_bus.dmem_wdata, exp_be, exp_wdata);
    end
    checks++; if (dmem_bus.dmem_addr !== {addr[31:2], 2'b00}) begin
      errors++; $display("FAIL st_addr got %h exp %h", dmem_bus.dmem_addr, {addr[31:2], 2'b00});
    end
    dmem_bus.dmem_ack = 1'b1;
    tick();
    dmem_bus.dmem_ack = 1'b0;
    checks++; if (wb_valid !== 1'b1 || dmem_bus.dmem_req !== 1'b0 || regwrite_out !== 1'b0) begin
      errors++; $display("FAIL st_done got wb_valid=%0h req=%0h rw=%0h exp 1 0 0", wb_valid, dmem_bus.dmem_req, regwrite_out);
    end
    tick();
  endtask

  task automatic test_misalign();
    drive_mem(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd7, 1'b1);
    tick();
    clear_ex();
    checks++; if (dmem_bus.dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
      errors++; $display("FAIL mis_noreq got req=%0h ready=%0h exp 0 1", dmem_bus.dmem_req, ex_ready);
    end
    checks++; if (wb_valid !== 1'b1 || misalign !== 1'b1 || regwrite_out !== 1'b0 || mem_out !== 32'h0) begin
      errors++; $display("FAIL mis_wb got wb=%0h mis=%0h rw=%0h mem_out=%h exp 1 1 0 0", wb_valid, misalign, regwrite_out, mem_out);
    end
    checks++; if (rd_out !== 5'd7 || alu_out !== 32'h101) begin
      errors++; $display("FAIL mis_fields got rd=%0d alu=%h exp 7 00000101", rd_out, alu_out);
    end
    tick();
    checks++; if (misalign !== 1'b0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL mis_pulse got mis=%0h wb=%0h exp 0 0", misalign, wb_valid);
    end
  endtask

  task automatic test_back_to_back();
    ex_valid = 1'b1; alu_result = 32'h1111_1111; rd_in = 5'd3; regwrite_in = 1'b1;
    imm_in = 32'hABC0_0000; return_addr_in = 32'h0000_0404; pc_off_in = 32'h0000_0880; opcode_in = 7'h33;
    tick();
    alu_result = 32'h2222_2222; rd_in = 5'd4; flush = 1'b1;
    checks++; if (ex_ready !== 1'b1 || wb_valid !== 1'b1 || alu_out !== 32'h1111_1111) begin
      errors++; $display("FAIL b2b_first got ready=%0h wb=%0h alu=%h exp 1 1 11111111", ex_ready, wb_valid, alu_out);
    end
    checks++; if (imm_out !== 32'hABC0_0000 || return_addr !== 32'h404 || pc_signed_offset !== 32'h880 || opcode_out_d !== 7'h33) begin
      errors++; $display("FAIL b2b_carry got imm=%h ra=%h pco=%h op=%h exp abc00000 00000404 00000880 33", imm_out, return_addr, pc_signed_offset, opcode_out_d);
    end
    tick();
    clear_ex();
    checks++; if (wb_valid !== 1'b0 || alu_out !== 32'h1111_1111 || rd_out !== 5'd3 || ex_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_flush got wb=%0h alu=%h rd=%0d ready=%0h exp 0 11111111 3 1", wb_valid, alu_out, rd_out, ex_ready);
    end
    tick();
  endtask

  task automatic test_reset_mid_access();
    drive_mem(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd11, 1'b1);
    tick();
    clear_ex();
    checks++; if (dmem_bus.dmem_req !== 1'b1) begin errors++; $display("FAIL rst_acc_req got %0h exp 1", dmem_bus.dmem_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if (dmem_bus.dmem_req !== 1'b0 || state_dbg !== 1'b0) begin
      errors++; $display("FAIL rst_acc_drop got req=%0h state=%0h exp 0 0", dmem_bus.dmem_req, state_dbg);
    end
    tick();
    rst = 1'b0;
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'h1234_5678;
    tick();
    dmem_bus.dmem_ack = 1'b0;
    checks++; if (wb_valid !== 1'b0 || dmem_bus.dmem_req !== 1'b0 || state_dbg !== 1'b0 || ex_ready !== 1'b1) begin
      errors++; $display("FAIL rst_acc_stray got wb=%0h req=%0h state=%0h ready=%0h exp 0 0 0 1", wb_valid, dmem_bus.dmem_req, state_dbg, ex_ready);
    end
    tick();
    checks++; if (wb_valid !== 1'b0 || mem_out !== 32'h0) begin
      errors++; $display("FAIL rst_acc_after got wb=%0h mem_out=%h exp 0 0", wb_valid, mem_out);
    end
  endtask

  initial begin
    clear_ex();
    test_reset();
    test_lw();
    test_lb_wait(3'b000, 32'hFFFF_FF80);
    test_lb_wait(3'b100, 32'h0000_0080);
    test_store(3'b001, 32'h0000_0202, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
    test_store(3'b000, 32'h0000_0101, 32'h0000_0055, 4'b0010, 32'h5555_5555);
    test_store(3'b010, 32'h0000_0204, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    test_misalign();
    test_back_to_back();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
